// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: one radix-2 step per cycle.
// Shift-add multiply and restoring divide on operand magnitudes, with a single
// sign/half-select cycle (FIX) before the result is presented.
// Optional feature macro: MDU_WORD_OP_EN enables the W-suffixed word variants.
module mdu_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic        op_w,
  input  logic [63:0] src_a,
  input  logic [63:0] src_b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = 7;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;

  // request decode
  logic              word_in, a_sgn, b_sgn, a_neg, b_neg;
  logic [2:0]        op_in;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_neg, byp_res;
  logic              div_zero, div_ovf, bypass, accept;
  // step / fix helpers
  logic              last_step, ge;
  logic [XLEN:0]     sh, dv, dif;
  logic [XLEN-1:0]   new_rem, quo, remv, fix_res;
  logic [PW-1:0]     prod;

  function automatic logic [XLEN-1:0] wsext(input logic [XLEN-1:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  assign in_ready  = (state_q == S_IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

  // Decode the incoming request: operand extension, magnitudes and bypass cases
  always_comb begin
`ifdef MDU_WORD_OP_EN
    word_in = op_w;
`else
    word_in = op_w & 1'b0;
`endif
    op_in = op;
    if (word_in && !op[2]) op_in = 3'd0;
    a_sgn = (op_in == 3'd0) | (op_in == 3'd1) | (op_in == 3'd2) |
            (op_in == 3'd4) | (op_in == 3'd6);
    b_sgn = (op_in == 3'd0) | (op_in == 3'd1) | (op_in == 3'd4) | (op_in == 3'd6);
    a_ext = src_a;
    b_ext = src_b;
    if (word_in) begin
      a_ext = a_sgn ? wsext(src_a) : {32'd0, src_a[31:0]};
      b_ext = b_sgn ? wsext(src_b) : {32'd0, src_b[31:0]};
    end
    a_neg = a_sgn & a_ext[XLEN-1];
    b_neg = b_sgn & b_ext[XLEN-1];
    a_mag = a_neg ? (XLEN'(0) - a_ext) : a_ext;
    b_mag = b_neg ? (XLEN'(0) - b_ext) : b_ext;
    min_neg  = word_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero = op_in[2] & (b_ext == '0);
    div_ovf  = op_in[2] & ~op_in[0] & (a_ext == min_neg) & (b_ext == '1);
    bypass   = div_zero | div_ovf;
    if (op_in[1]) byp_res = div_zero ? a_ext : '0;
    else          byp_res = div_zero ? '1 : a_ext;
    if (word_in) byp_res = wsext(byp_res);
  end

  // Per-step arithmetic and final sign correction / half select
  always_comb begin
    last_step = word_q ? (cnt_q == CW'(31)) : (cnt_q == CW'(XLEN - 1));
    sh      = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
    dv      = {1'b0, mcand_q[XLEN-1:0]};
    ge      = (sh >= dv);
    dif     = sh - dv;
    new_rem = ge ? dif[XLEN-1:0] : sh[XLEN-1:0];
    prod    = negq_q ? (PW'(0) - acc_q) : acc_q;
    quo     = negq_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    remv    = negr_q ? (XLEN'(0) - acc_q[PW-1:XLEN]) : acc_q[PW-1:XLEN];
    case (op_q)
      3'd0:       fix_res = prod[XLEN-1:0];
      3'd4, 3'd5: fix_res = quo;
      3'd6, 3'd7: fix_res = remv;
      default:    fix_res = prod[PW-1:XLEN];
    endcase
    if (word_q) fix_res = wsext(fix_res);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush wins over every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = bypass ? S_DONE : S_CALC;
      S_CALC: if (last_step) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath and output next values
  always_comb begin
    op_d        = op_q;
    word_d      = word_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = op_in;
          word_d = word_in;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          cnt_d  = '0;
          if (op_in[2]) begin
            mcand_d  = {64'd0, b_mag};
            mplier_d = '0;
            acc_d    = {64'd0, (word_in ? {a_mag[31:0], 32'd0} : a_mag)};
          end else begin
            mcand_d  = {64'd0, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
          end
          if (bypass) begin
            result_d    = byp_res;
            out_valid_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[2]) begin
          acc_d = {new_rem, acc_q[XLEN-2:0], ge};
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
          mcand_d  = {mcand_q[PW-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        end
      end
      S_FIX: begin
        result_d    = fix_res;
        out_valid_d = 1'b1;
      end
      S_DONE: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
    if (flush) begin
      out_valid_d = 1'b0;
      result_d    = result_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      word_q      <= 1'b0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      op_q        <= op_d;
      word_q      <= word_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, op_w, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] src_a, src_b, result;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          seen;
  logic [63:0] held;

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_w(op_w), .src_a(src_a), .src_b(src_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after its acceptance edge.
  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    int n = 0;
    while (!in_ready && n < 10) begin tick(); n++; end
    chk("issue_ready", 64'(in_ready), 64'd1);
    op = o; op_w = w; src_a = a; src_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency = number of edges from acceptance until out_valid is sampled high.
  task automatic wait_out(output int l);
    int n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    l = out_valid ? n + 1 : -1;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'd0; op_w = 1'b0; src_a = '0; src_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);

    // MUL 7 * -3
    issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_busy", 64'(busy), 64'd1);
    chk("mul_in_ready", 64'(in_ready), 64'd0);
    wait_out(lat);
    chk("mul_lat", 64'(lat), 64'd66);
    chk("mul_res", result, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("done_in_ready", 64'(in_ready), 64'd0);
    handoff();
    chk("mul_idle_valid", 64'(out_valid), 64'd0);
    chk("mul_idle_busy", 64'(busy), 64'd0);
    chk("mul_idle_ready", 64'(in_ready), 64'd1);
    chk("idle_hold", result, 64'hFFFF_FFFF_FFFF_FFEB);

    // DIV / REM signed overflow
    issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1);
    wait_out(lat);
    chk("divovf_lat", 64'(lat), 64'd1);
    chk("divovf_res", result, 64'h8000_0000_0000_0000);
    handoff();
    issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1);
    wait_out(lat);
    chk("removf_lat", 64'(lat), 64'd1);
    chk("removf_res", result, 64'd0);
    handoff();

    // DIVU / REMU by zero
    issue(3'd5, 1'b0, 64'd100, 64'd0);
    wait_out(lat);
    chk("divz_lat", 64'(lat), 64'd1);
    chk("divz_res", result, '1);
    handoff();
    issue(3'd7, 1'b0, 64'd100, 64'd0);
    wait_out(lat);
    chk("remz_lat", 64'(lat), 64'd1);
    chk("remz_res", result, 64'd100);
    handoff();

    // MULHU max * max with held-off consumer
    issue(3'd3, 1'b0, '1, '1);
    wait_out(lat);
    chk("mulhu_lat", 64'(lat), 64'd66);
    chk("mulhu_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 5; i++) tick();
    chk("mulhu_hold_valid", 64'(out_valid), 64'd1);
    chk("mulhu_hold_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    handoff();
    chk("mulhu_idle_busy", 64'(busy), 64'd0);
    chk("mulhu_idle_valid", 64'(out_valid), 64'd0);

    // MULHSU: -1 (signed) * 2^64-1 (unsigned)
    issue(3'd2, 1'b0, '1, '1);
    wait_out(lat);
    chk("mulhsu_res", result, '1);
    handoff();

    // DIVW -7 / 2 (64-bit DIV of the zero-extended value without word support)
    issue(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);
    wait_out(lat);
`ifdef MDU_WORD_OP_EN
    chk("divw_lat", 64'(lat), 64'd34);
    chk("divw_res", result, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    chk("divw_lat", 64'(lat), 64'd66);
    chk("divw_res", result, 64'h0000_0000_7FFF_FFFC);
`endif
    handoff();

    // REM -100 % 7 with inputs disturbed after acceptance
    issue(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
    op = 3'd0; src_a = 64'd3; src_b = 64'd5;
    wait_out(lat);
    chk("rem_lat", 64'(lat), 64'd66);
    chk("rem_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    handoff();
    held = result;

    // flush at cycle 10 of CALC
    issue(3'd0, 1'b0, 64'd9, 64'd9);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_res_hold", result, held);
    seen = 0;
    for (int i = 0; i < 70; i++) begin tick(); if (out_valid) seen++; end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // reset mid-CALC, with flush and in_valid also asserted
    issue(3'd1, 1'b0, 64'd5, 64'd6);
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_result", result, 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin tick(); if (out_valid) seen++; end
    chk("rstmid_no_valid", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  RV64M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 op_w  input  1  word variant (MULW/DIVW/DIVUW/REMW/REMUW).
REQ-008 src_a  input  64  operand A (rs1 value).
REQ-009 src_b  input  64  operand B, taken from the ALU B-operand select output.
REQ-010 flush  input  1  abort the in-flight operation.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  64  final result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, CALC, FIX, DONE.
REQ-016 Acceptance SHALL occur on an edge where in_valid & in_ready; in_ready SHALL equal (state==IDLE) & ~flush.
REQ-017 On acceptance, op/op_w/operands SHALL be latched; later input changes SHALL have no effect.
REQ-018 Operands SHALL be converted to magnitudes per op signedness (MULHSU: A signed, B unsigned), with result sign recorded.
REQ-019 CALC SHALL run one radix-2 step per cycle (shift-add multiply, restoring divide), 64 steps, or 32 steps when op_w.
REQ-020 After the last step, state SHALL go to FIX for one cycle (sign correction, high/low half select, word sign-extension), then to DONE.
REQ-021 Latency SHALL be: out_valid high 66 cycles after the acceptance edge (34 cycles for op_w).
REQ-022 Divide by zero SHALL bypass CALC/FIX and enter DONE directly (out_valid 1 cycle after acceptance): quotient all ones, remainder = dividend.
REQ-023 Signed overflow (most-negative / -1, at 64 or 32 bits) SHALL take the same 1-cycle bypass: quotient = dividend, remainder 0.
REQ-024 Word results SHALL be bit 31 of the 32-bit result sign-extended to 64 bits; word operands SHALL be the low 32 bits, sign- or zero-extended per op.
REQ-025 op_w with op 1/2/3 SHALL be treated as MULW (op 0).
REQ-026 In DONE, out_valid and result SHALL hold stable until out_ready; on out_valid & out_ready, the next state SHALL be IDLE.
REQ-027 A new request SHALL NOT be accepted in the same cycle as result handoff (in_ready goes high the cycle after).
REQ-028 flush in any state SHALL force IDLE on the next edge with out_valid low, discard the result, and block acceptance that cycle.
REQ-029 In IDLE, result SHALL hold its last value.

Reset
REQ-030 reset SHALL set state IDLE, out_valid 0, busy 0, result 0, and step counter 0, overriding flush and in_valid.
REQ-031 reset mid-CALC SHALL discard the operation; no out_valid SHALL follow.

Configuration
REQ-032 The macro MDU_WORD_OP_EN SHALL control word-variant support.
REQ-033 With MDU_WORD_OP_EN defined, op_w SHALL behave per REQ-019/021/024/025.
REQ-034 Without MDU_WORD_OP_EN, op_w SHALL be ignored and treated as 0; all ops SHALL be 64-bit with 66-cycle latency.

Verification
REQ-035 MUL with A=7, B=-3, op=0 -> after 66 cycles, result 0xFFFFFFFFFFFFFFEB.
REQ-036 DIV with A=0x8000000000000000, B=-1 -> 1 cycle later, result 0x8000000000000000; REM with the same operands -> 0.
REQ-037 DIVU with A=100, B=0 -> 1 cycle later, result 0xFFFFFFFFFFFFFFFF; REMU with the same operands -> 100.
REQ-038 MULHU with A=B=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE; keep out_ready low 5 cycles -> result stable, then IDLE one edge after handshake.
REQ-039 With MDU_WORD_OP_EN defined: DIVW with A=0x00000000FFFFFFF9 (-7), B=2 -> after 34 cycles, result 0xFFFFFFFFFFFFFFFD.
REQ-040 flush at cycle 10 of CALC -> IDLE next edge, no out_valid; reset mid-CALC -> same, and all outputs 0.
